// File: rtl/roce_tx_pkg.sv
// Shared RoCEv2 TX definitions: RC WRITE opcodes, sequencer states and the
// opcode/PMTU helpers used by the write sequencer.
package roce_tx_pkg;

   localparam logic [7:0] OP_WRITE_FIRST    = 8'h06;
   localparam logic [7:0] OP_WRITE_MIDDLE   = 8'h07;
   localparam logic [7:0] OP_WRITE_LAST     = 8'h08;
   localparam logic [7:0] OP_WRITE_LAST_IMM = 8'h09;
   localparam logic [7:0] OP_WRITE_ONLY     = 8'h0A;
   localparam logic [7:0] OP_WRITE_ONLY_IMM = 8'h0B;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ISSUE     = 2'd1,
      ST_WAIT_DONE = 2'd2
   } seq_state_e;

   function automatic bit pmtu_legal(input int bytes);
      return (bytes == 256) || (bytes == 512) || (bytes == 1024) ||
             (bytes == 2048) || (bytes == 4096);
   endfunction

   function automatic logic [7:0] write_opcode(input logic first, input logic last,
                                               input logic imm_en);
      if (first && last) return imm_en ? OP_WRITE_ONLY_IMM : OP_WRITE_ONLY;
      if (first)         return OP_WRITE_FIRST;
      if (last)          return imm_en ? OP_WRITE_LAST_IMM : OP_WRITE_LAST;
      return OP_WRITE_MIDDLE;
   endfunction

endpackage

// File: rtl/roce_tx_write_sequencer.sv
// Splits an RDMA WRITE work request into PMTU-sized packets and hands one
// header descriptor at a time to the header producer.
//
// state        | meaning
// ST_IDLE      | ready for a work request or a PSN load
// ST_ISSUE     | descriptor presented, waiting for m_pkt_ready
// ST_WAIT_DONE | descriptor taken, waiting for the packet's payload_last
module roce_tx_write_sequencer
   import roce_tx_pkg::*;
#(
   parameter int PMTU_BYTES = 1024,
   parameter int LEN_WIDTH  = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 s_req_valid,
   output logic                 s_req_ready,
   input  logic [LEN_WIDTH-1:0] s_req_length,
   input  logic [63:0]          s_req_v_addr,
   input  logic [31:0]          s_req_r_key,
   input  logic [23:0]          s_req_dest_qp,
   input  logic                 s_req_imm_en,
   input  logic [31:0]          s_req_imm_data,
   input  logic                 cfg_psn_load,
   input  logic [23:0]          cfg_start_psn,
   output logic                 m_pkt_valid,
   input  logic                 m_pkt_ready,
   output logic [7:0]           m_pkt_op_code,
   output logic [23:0]          m_pkt_psn,
   output logic [23:0]          m_pkt_dest_qp,
   output logic                 m_pkt_ack_req,
   output logic [15:0]          m_pkt_payload_len,
   output logic                 m_pkt_reth_valid,
   output logic [63:0]          m_pkt_v_addr,
   output logic [31:0]          m_pkt_r_key,
   output logic [31:0]          m_pkt_dma_length,
   output logic                 m_pkt_immdh_valid,
   output logic [31:0]          m_pkt_imm_data,
   input  logic                 payload_last,
   output logic                 busy,
   output logic                 err_zero_len
);

   if (!pmtu_legal(PMTU_BYTES)) begin : g_pmtu_check
      $error("PMTU_BYTES must be a power of two in 256..4096");
   end

   localparam logic [LEN_WIDTH-1:0] PMTU_L = LEN_WIDTH'(PMTU_BYTES);

   seq_state_e           state;
   logic [23:0]          psn_q;
   logic [LEN_WIDTH-1:0] remaining_q;
   logic                 imm_en_q;

   logic [LEN_WIDTH-1:0] rem_nxt;
   logic                 first_nxt;
   logic                 last_nxt;
   logic                 imm_en_nxt;
   logic [15:0]          len_nxt;
   logic                 req_fire;
   logic                 launch;

   assign s_req_ready = (state == ST_IDLE) && !cfg_psn_load;
   assign req_fire    = s_req_valid && s_req_ready;
   assign m_pkt_valid = (state == ST_ISSUE);
   assign busy        = (state != ST_IDLE);
   assign m_pkt_psn   = psn_q;

   // Next packet is derived either from a fresh request or from what is left
   // after the packet whose payload just finished.
   always_comb begin
      rem_nxt    = remaining_q - LEN_WIDTH'(m_pkt_payload_len);
      first_nxt  = 1'b0;
      imm_en_nxt = imm_en_q;
      if (state == ST_IDLE) begin
         rem_nxt    = s_req_length;
         first_nxt  = 1'b1;
         imm_en_nxt = s_req_imm_en;
      end
      last_nxt = (rem_nxt <= PMTU_L);
      len_nxt  = last_nxt ? 16'(rem_nxt) : 16'(PMTU_BYTES);
      launch   = ((state == ST_IDLE) && req_fire && (s_req_length != '0)) ||
                 ((state == ST_WAIT_DONE) && payload_last && (rem_nxt != '0));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state             <= ST_IDLE;
         psn_q             <= '0;
         remaining_q       <= '0;
         imm_en_q          <= 1'b0;
         err_zero_len      <= 1'b0;
         m_pkt_op_code     <= '0;
         m_pkt_dest_qp     <= '0;
         m_pkt_ack_req     <= 1'b0;
         m_pkt_payload_len <= '0;
         m_pkt_reth_valid  <= 1'b0;
         m_pkt_v_addr      <= '0;
         m_pkt_r_key       <= '0;
         m_pkt_dma_length  <= '0;
         m_pkt_immdh_valid <= 1'b0;
         m_pkt_imm_data    <= '0;
      end else begin
         err_zero_len <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (cfg_psn_load) begin
                  psn_q <= cfg_start_psn;
               end else if (s_req_valid) begin
                  if (s_req_length == '0) begin
                     err_zero_len <= 1'b1;
                  end else begin
                     state            <= ST_ISSUE;
                     m_pkt_dest_qp    <= s_req_dest_qp;
                     m_pkt_reth_valid <= 1'b1;
                     m_pkt_v_addr     <= s_req_v_addr;
                     m_pkt_r_key      <= s_req_r_key;
                     m_pkt_dma_length <= 32'(s_req_length);
                     m_pkt_imm_data   <= s_req_imm_data;
                  end
               end
            end
            ST_ISSUE: begin
               if (m_pkt_ready) state <= ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
               if (payload_last) begin
                  psn_q            <= psn_q + 24'd1;
                  m_pkt_reth_valid <= 1'b0;
                  state            <= (rem_nxt == '0) ? ST_IDLE : ST_ISSUE;
               end
            end
            default: state <= ST_IDLE;
         endcase
         if (launch) begin
            remaining_q       <= rem_nxt;
            imm_en_q          <= imm_en_nxt;
            m_pkt_payload_len <= len_nxt;
            m_pkt_op_code     <= write_opcode(first_nxt, last_nxt, imm_en_nxt);
            m_pkt_ack_req     <= last_nxt;
            m_pkt_immdh_valid <= last_nxt && imm_en_nxt;
         end
      end
   end

endmodule

// File: tb/tb_roce_tx_write_sequencer.sv
// Scoreboard bench for roce_tx_write_sequencer: directed requests push hand-computed
// descriptors, a monitor pops and compares them on each descriptor handshake.
module tb_roce_tx_write_sequencer;

   localparam int LEN_W = 32;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             s_req_valid, s_req_ready;
   logic [LEN_W-1:0] s_req_length;
   logic [63:0]      s_req_v_addr;
   logic [31:0]      s_req_r_key;
   logic [23:0]      s_req_dest_qp;
   logic             s_req_imm_en;
   logic [31:0]      s_req_imm_data;
   logic             cfg_psn_load;
   logic [23:0]      cfg_start_psn;
   logic             m_pkt_valid, m_pkt_ready;
   logic [7:0]       m_pkt_op_code;
   logic [23:0]      m_pkt_psn, m_pkt_dest_qp;
   logic             m_pkt_ack_req;
   logic [15:0]      m_pkt_payload_len;
   logic             m_pkt_reth_valid;
   logic [63:0]      m_pkt_v_addr;
   logic [31:0]      m_pkt_r_key, m_pkt_dma_length;
   logic             m_pkt_immdh_valid;
   logic [31:0]      m_pkt_imm_data;
   logic             payload_last, busy, err_zero_len;

   roce_tx_write_sequencer #(.PMTU_BYTES(1024), .LEN_WIDTH(LEN_W)) dut (
      .clk(clk), .rst(rst),
      .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
      .s_req_length(s_req_length), .s_req_v_addr(s_req_v_addr),
      .s_req_r_key(s_req_r_key), .s_req_dest_qp(s_req_dest_qp),
      .s_req_imm_en(s_req_imm_en), .s_req_imm_data(s_req_imm_data),
      .cfg_psn_load(cfg_psn_load), .cfg_start_psn(cfg_start_psn),
      .m_pkt_valid(m_pkt_valid), .m_pkt_ready(m_pkt_ready),
      .m_pkt_op_code(m_pkt_op_code), .m_pkt_psn(m_pkt_psn),
      .m_pkt_dest_qp(m_pkt_dest_qp), .m_pkt_ack_req(m_pkt_ack_req),
      .m_pkt_payload_len(m_pkt_payload_len), .m_pkt_reth_valid(m_pkt_reth_valid),
      .m_pkt_v_addr(m_pkt_v_addr), .m_pkt_r_key(m_pkt_r_key),
      .m_pkt_dma_length(m_pkt_dma_length), .m_pkt_immdh_valid(m_pkt_immdh_valid),
      .m_pkt_imm_data(m_pkt_imm_data), .payload_last(payload_last),
      .busy(busy), .err_zero_len(err_zero_len)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  op;
      logic [23:0] psn;
      logic [15:0] len;
      logic        reth, ack, immdh, last;
      logic [63:0] va;
      logic [31:0] rkey, dlen, imm;
      logic [23:0] qp;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          checks = 0;
   int          errors = 0;
   int          pend_cnt = 0;
   bit          stall = 0, force_last = 0, cur_last = 0;
   logic [63:0] r_va;
   logic [31:0] r_rkey, r_imm, r_len;
   logic [23:0] r_qp;
   logic        r_imm_en;
   logic [255:0] fields_now, snap;

   assign fields_now = 256'({m_pkt_op_code, m_pkt_psn, m_pkt_payload_len, m_pkt_ack_req,
                             m_pkt_reth_valid, m_pkt_v_addr, m_pkt_r_key, m_pkt_dma_length,
                             m_pkt_immdh_valid, m_pkt_imm_data, m_pkt_dest_qp});

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_req(input logic [31:0] len, input logic [63:0] va, input logic [31:0] rkey,
                          input logic [23:0] qp, input logic imm_en, input logic [31:0] imm);
      r_len = len; r_va = va; r_rkey = rkey; r_qp = qp; r_imm_en = imm_en; r_imm = imm;
   endtask

   task automatic push(input logic [7:0] op, input logic [23:0] psn, input logic [15:0] len,
                       input bit reth, input bit ack, input bit immdh, input bit last);
      exp_t e;
      e.op = op; e.psn = psn; e.len = len; e.reth = reth; e.ack = ack; e.immdh = immdh;
      e.last = last; e.va = r_va; e.rkey = r_rkey; e.dlen = r_len; e.imm = r_imm; e.qp = r_qp;
      exp_q.push_back(e);
   endtask

   task automatic drive_req();
      s_req_valid = 1'b1; s_req_length = r_len; s_req_v_addr = r_va; s_req_r_key = r_rkey;
      s_req_dest_qp = r_qp; s_req_imm_en = r_imm_en; s_req_imm_data = r_imm;
   endtask

   task automatic send_req(input bit expect_pkt);
      int t = 0;
      @(posedge clk); #1;
      drive_req();
      forever begin
         @(negedge clk);
         if (s_req_ready) break;
         t++;
         if (t > 500) begin chk("req_accept_timeout", 256'(t), 256'(0)); break; end
      end
      @(posedge clk); #1;
      s_req_valid = 1'b0;
      @(negedge clk);
      if (expect_pkt) begin
         chk("valid_latency", m_pkt_valid, 1);
      end else begin
         chk("err_zero_len_pulse", err_zero_len, 1);
         chk("zero_len_busy", busy, 0);
         @(negedge clk);
         chk("err_zero_len_single", err_zero_len, 0);
      end
   endtask

   task automatic wait_idle(input logic [23:0] psn_exp);
      int t = 0;
      do begin
         @(negedge clk);
         t++;
      end while ((busy || exp_q.size() != 0) && t < 5000);
      chk("idle_timeout", 256'(t >= 5000), 0);
      chk("psn_after_req", m_pkt_psn, psn_exp);
   endtask

   task automatic load_psn(input logic [23:0] v);
      @(posedge clk); #1;
      cfg_psn_load = 1'b1; cfg_start_psn = v;
      @(posedge clk); #1;
      cfg_psn_load = 1'b0;
      @(negedge clk);
      chk("psn_load", m_pkt_psn, v);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_valid"}, m_pkt_valid, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_ready"}, s_req_ready, 1);
      chk({tag, "_err"}, err_zero_len, 0);
      chk({tag, "_fields"}, fields_now, 256'd0);
   endtask

   always @(negedge clk) begin
      if (!rst && m_pkt_valid && m_pkt_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pkt: got op %0h psn %0h len %0d, required no packet",
                     m_pkt_op_code, m_pkt_psn, m_pkt_payload_len);
         end else begin
            mon_e = exp_q.pop_front();
            chk("pkt_op", m_pkt_op_code, mon_e.op);
            chk("pkt_psn", m_pkt_psn, mon_e.psn);
            chk("pkt_len", m_pkt_payload_len, mon_e.len);
            chk("pkt_reth_valid", m_pkt_reth_valid, mon_e.reth);
            chk("pkt_ack_req", m_pkt_ack_req, mon_e.ack);
            chk("pkt_immdh_valid", m_pkt_immdh_valid, mon_e.immdh);
            chk("pkt_reth_fields", {m_pkt_v_addr, m_pkt_r_key, m_pkt_dma_length},
                {mon_e.va, mon_e.rkey, mon_e.dlen});
            chk("pkt_qp_imm", {m_pkt_dest_qp, m_pkt_imm_data}, {mon_e.qp, mon_e.imm});
            cur_last = mon_e.last;
         end
         pend_cnt = 3;
      end
   end

   // Header-producer stand-in: accepts descriptors and returns payload_last a few cycles later.
   initial begin
      bit lastp;
      m_pkt_ready  = 1'b1;
      payload_last = 1'b0;
      forever begin
         @(posedge clk); #1;
         m_pkt_ready  = !stall;
         payload_last = force_last;
         if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
               lastp        = cur_last;
               payload_last = 1'b1;
               @(posedge clk); #1;
               payload_last = force_last;
               m_pkt_ready  = !stall;
               @(negedge clk);
               if (!rst) begin
                  if (lastp) chk("idle_after_last", {busy, m_pkt_valid}, 2'b00);
                  else       chk("next_pkt_valid", m_pkt_valid, 1);
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached with %0d checks, required finish earlier", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      s_req_valid = 0; s_req_length = '0; s_req_v_addr = '0; s_req_r_key = '0;
      s_req_dest_qp = '0; s_req_imm_en = 0; s_req_imm_data = '0;
      cfg_psn_load = 0; cfg_start_psn = '0;
      #1;
      chk_reset_vals("in_reset");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk_reset_vals("after_reset");

      // single-packet request, then PSN carry-over
      load_psn(24'h000100);
      set_req(1024, 64'h0000_1000_2000_3000, 32'h1111_2222, 24'h000AAA, 0, 32'h0);
      push(8'h0A, 24'h000100, 16'd1024, 1, 1, 0, 1);
      send_req(1);
      wait_idle(24'h000101);
      set_req(100, 64'h0000_0000_0000_4000, 32'h3333_4444, 24'h000BBB, 0, 32'h0);
      push(8'h0A, 24'h000101, 16'd100, 1, 1, 0, 1);
      send_req(1);
      wait_idle(24'h000102);

      // three packets with a short tail
      set_req(2600, 64'h0000_00AB_CDEF_0000, 32'h5555_6666, 24'h123456, 0, 32'h0);
      push(8'h06, 24'h000102, 16'd1024, 1, 0, 0, 0);
      push(8'h07, 24'h000103, 16'd1024, 0, 0, 0, 0);
      push(8'h08, 24'h000104, 16'd552, 0, 1, 0, 1);
      send_req(1);
      wait_idle(24'h000105);

      // immediate on the final packet
      set_req(2048, 64'h0000_0000_0000_8000, 32'h7777_8888, 24'h00CCCC, 1, 32'hDEADBEEF);
      push(8'h06, 24'h000105, 16'd1024, 1, 0, 0, 0);
      push(8'h09, 24'h000106, 16'd1024, 0, 1, 1, 1);
      send_req(1);
      wait_idle(24'h000107);

      // PSN wrap
      load_psn(24'hFFFFFF);
      set_req(3000, 64'hFFFF_0000_0000_0000, 32'h9999_AAAA, 24'hFFFFFF, 0, 32'h0);
      push(8'h06, 24'hFFFFFF, 16'd1024, 1, 0, 0, 0);
      push(8'h07, 24'h000000, 16'd1024, 0, 0, 0, 0);
      push(8'h08, 24'h000001, 16'd952, 0, 1, 0, 1);
      send_req(1);
      wait_idle(24'h000002);

      // back-pressure with spurious payload_last while the descriptor is held
      stall = 1;
      @(posedge clk); #2;
      set_req(500, 64'h0000_0000_1234_5678, 32'hBBBB_CCCC, 24'h000777, 1, 32'hCAFEF00D);
      push(8'h0B, 24'h000002, 16'd500, 1, 1, 1, 1);
      send_req(1);
      force_last = 1;
      snap = fields_now;
      repeat (5) begin
         @(negedge clk);
         chk("stall_valid_held", m_pkt_valid, 1);
         chk("stall_fields_stable", fields_now, snap);
      end
      force_last = 0;
      stall = 0;
      wait_idle(24'h000003);

      // zero-length request is dropped
      set_req(0, 64'h0, 32'h0, 24'h000001, 0, 32'h0);
      send_req(0);
      repeat (4) @(negedge clk);
      chk("zero_len_no_advance", {busy, m_pkt_psn}, {1'b0, 24'h000003});

      // PSN load wins over a simultaneous request
      set_req(1500, 64'h0000_0000_0000_C000, 32'hDDDD_EEEE, 24'h000321, 0, 32'h0);
      push(8'h06, 24'h00ABCD, 16'd1024, 1, 0, 0, 0);
      push(8'h08, 24'h00ABCE, 16'd476, 0, 1, 0, 1);
      @(posedge clk); #1;
      cfg_psn_load = 1'b1; cfg_start_psn = 24'h00ABCD;
      drive_req();
      @(negedge clk);
      chk("load_blocks_ready", s_req_ready, 0);
      @(posedge clk); #1;
      cfg_psn_load = 1'b0;
      @(negedge clk);
      chk("load_applied", {s_req_ready, m_pkt_psn}, {1'b1, 24'h00ABCD});
      @(posedge clk); #1;
      s_req_valid = 1'b0;
      @(negedge clk);
      chk("load_req_valid", m_pkt_valid, 1);
      wait_idle(24'h00ABCF);

      // reset while waiting for payload completion
      set_req(3000, 64'h0000_0000_0000_E000, 32'h0F0F_0F0F, 24'h000999, 1, 32'h12345678);
      push(8'h06, 24'h00ABCF, 16'd1024, 1, 0, 0, 0);
      send_req(1);
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!(busy && !m_pkt_valid) && t < 100);
      chk("wait_done_timeout", 256'(t >= 100), 0);
      #2;
      rst = 1'b1;
      pend_cnt = 0;
      exp_q.delete();
      #1;
      chk_reset_vals("async_reset");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_vals("post_abort");
      set_req(64, 64'h0000_0000_0000_0040, 32'h0000_0001, 24'h000002, 0, 32'h0);
      push(8'h0A, 24'h000000, 16'd64, 1, 1, 0, 1);
      send_req(1);
      wait_idle(24'h000001);

      repeat (5) @(negedge clk);
      chk("scoreboard_drained", 256'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
